// File: rtl/des3_job_arbiter_if.sv
// Job/core/response signal bundle for des3_job_arbiter.
// "slave" is the arbiter's view; "master" is everything around it (requesters, core, consumer).
interface des3_job_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_data0;
  logic [63:0] req_data1;
  logic [1:0]  req_decrypt;
  logic        key_ready;
  logic        core_start;
  logic [63:0] core_desIn;
  logic        core_decrypt;
  logic        core_out_valid;
  logic [63:0] core_desOut;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_id;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_data0, req_data1, req_decrypt, key_ready,
           core_out_valid, core_desOut, rsp_ready,
    input  req_ready, core_start, core_desIn, core_decrypt,
           rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_data0, req_data1, req_decrypt, key_ready,
           core_out_valid, core_desOut, rsp_ready,
    output req_ready, core_start, core_desIn, core_decrypt,
           rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );
endinterface

// File: rtl/des3_job_arbiter.sv
// Round-robin arbiter feeding one des3 core from two requesters, with a
// completion timeout and a held response port.
module des3_job_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  des3_job_arbiter_if.slave bus
);
  localparam int NUM_REQ = 2;
  localparam logic [7:0] TC = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        decrypt;
    logic        id;
  } job_t;

  state_t state, state_nxt;

  logic                          last_grant, last_grant_d;
  logic [7:0]                    cnt, cnt_d;
  job_t                          job, job_d;
  logic                          core_start_q, core_start_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [63:0]                   rsp_data_q, rsp_data_d;
  logic                          rsp_id_q, rsp_id_d;
  logic                          rsp_err_q, rsp_err_d;
  logic                          busy_q, busy_d;
  logic                          grant_id;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0][63:0]      req_data;

  assign req_data = {bus.req_data1, bus.req_data0};

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant_id = bus.req_valid[1];
    if (&bus.req_valid) grant_id = ~last_grant;
  end

  assign grant         = (state == IDLE && bus.key_ready && |bus.req_valid)
                         ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.req_ready = grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = BUSY;
      BUSY:    if (bus.core_out_valid || cnt == TC) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output, keyed off the current state.
  always_comb begin
    core_start_d = (state_nxt == ISSUE);
    busy_d       = (state_nxt != IDLE);
    rsp_valid_d  = (state_nxt == RESP);
    last_grant_d = last_grant;
    cnt_d        = cnt;
    job_d        = job;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    case (state)
      IDLE: begin
        if (|grant) begin
          last_grant_d = grant_id;
          job_d.data    = req_data[grant_id];
          job_d.decrypt = bus.req_decrypt[grant_id];
          job_d.id      = grant_id;
        end
      end
      ISSUE: cnt_d = 8'd0;
      BUSY: begin
        // A result on the terminal-count cycle still beats the timeout.
        if (bus.core_out_valid) begin
          rsp_data_d = bus.core_desOut;
          rsp_err_d  = 1'b0;
          rsp_id_d   = job.id;
        end else if (cnt == TC) begin
          rsp_data_d = 64'd0;
          rsp_err_d  = 1'b1;
          rsp_id_d   = job.id;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant   <= 1'b1;
      cnt          <= 8'd0;
      job          <= '0;
      core_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 64'd0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      last_grant   <= last_grant_d;
      cnt          <= cnt_d;
      job          <= job_d;
      core_start_q <= core_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.core_start   = core_start_q;
  assign bus.core_desIn   = job.data;
  assign bus.core_decrypt = job.decrypt;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_des3_job_arbiter.sv
// Scoreboard bench for des3_job_arbiter: random requesters, key and consumer,
// a latency-programmable core model, and a job-level reference model.
module tb_des3_job_arbiter;
  localparam int T = 12;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  des3_job_arbiter_if bus();
  des3_job_arbiter #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { bit id; logic [63:0] data; bit err; int rlat; } rsp_t;
  typedef struct { logic [63:0] data; bit dec; int lat; } job_t;

  rsp_t rsp_q[$];
  job_t core_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, grant_cyc = 0, start_cyc = 0;
  int   grant_cnt [2] = '{0, 0};
  int   seen      [2] = '{0, 0};
  int   req_lat   [2] = '{0, 0};
  bit   model_last = 1'b1, job_active = 1'b0, rand_mode = 1'b0;
  logic prev_rv = 1'b0, prev_rr = 1'b0, prev_id = 1'b0, prev_err = 1'b0;
  logic [63:0] prev_data = 64'd0;

  // Stand-in for the cipher: any fixed bijection of (block, direction).
  function automatic logic [63:0] core_fn(input logic [63:0] d, input logic dec);
    if (dec) return {d[31:0], d[63:32]} ^ 64'hA5A5_5A5A_C3C3_3C3C;
    return (d ^ 64'h0F1E_2D3C_4B5A_6978) + 64'd1;
  endfunction

  // 0 = core never answers; T and T+1 sit either side of the timeout.
  function automatic int pick_lat();
    case ($urandom_range(0, 9))
      0:       return 0;
      1:       return T;
      2:       return T + 1;
      3:       return 1;
      4:       return T - 1;
      default: return int'($urandom_range(1, T));
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_core_start"},   64'(bus.core_start),   64'd0);
    check({nm, "_core_desIn"},   bus.core_desIn,        64'd0);
    check({nm, "_core_decrypt"}, 64'(bus.core_decrypt), 64'd0);
    check({nm, "_rsp_valid"},    64'(bus.rsp_valid),    64'd0);
    check({nm, "_rsp_data"},     bus.rsp_data,          64'd0);
    check({nm, "_rsp_id"},       64'(bus.rsp_id),       64'd0);
    check({nm, "_rsp_err"},      64'(bus.rsp_err),      64'd0);
    check({nm, "_busy"},         64'(bus.busy),         64'd0);
    check({nm, "_req_ready"},    64'(bus.req_ready),    64'd0);
  endtask

  task automatic new_job(input int i, input logic [63:0] d, input logic dec, input int lat);
    bus.req_valid[i]   = 1'b1;
    bus.req_decrypt[i] = dec;
    req_lat[i]         = lat;
    if (i == 0) bus.req_data0 = d;
    else        bus.req_data1 = d;
  endtask

  // One clock: requesters drop a granted request, random traffic if enabled.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (grant_cnt[i] != seen[i]) begin
        seen[i] = grant_cnt[i];
        bus.req_valid[i] = 1'b0;
      end
      if (rand_mode && !bus.req_valid[i] && $urandom_range(0, 2) != 0)
        new_job(i, {$urandom, $urandom}, 1'($urandom_range(0, 1)), pick_lat());
    end
    if (rand_mode) begin
      bus.key_ready = ($urandom_range(0, 7) != 0);
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic wait_until_idle(input string nm);
    int k;
    k = 0;
    while ((job_active || rsp_q.size() != 0 || bus.req_valid != 2'b00) && k < 1000) begin
      tick();
      k++;
    end
    check(nm, 64'(k < 1000), 64'd1);
  endtask

  // Monitor and reference model: one job in flight, round-robin on ties.
  logic [1:0] exp_rdy;
  bit         w;
  rsp_t       r;
  job_t       gj;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      model_last = 1'b1;
      job_active = 1'b0;
      rsp_q.delete();
      core_q.delete();
      prev_rv = 1'b0;
      prev_rr = 1'b0;
    end else begin
      check("busy", 64'(bus.busy), 64'(job_active));
      exp_rdy = 2'b00;
      w = 1'b0;
      if (!job_active && bus.key_ready && bus.req_valid != 2'b00) begin
        w = (bus.req_valid == 2'b11) ? !model_last : bus.req_valid[1];
        exp_rdy = w ? 2'b10 : 2'b01;
      end
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      if (exp_rdy != 2'b00) begin
        gj.data = w ? bus.req_data1 : bus.req_data0;
        gj.dec  = bus.req_decrypt[w];
        gj.lat  = req_lat[w];
        core_q.push_back(gj);
        r.id   = w;
        r.err  = !(gj.lat >= 1 && gj.lat <= T);
        r.data = r.err ? 64'd0 : core_fn(gj.data, gj.dec);
        r.rlat = r.err ? T + 1 : gj.lat + 1;
        rsp_q.push_back(r);
        model_last = w;
        job_active = 1'b1;
        grant_cyc  = cyc;
        grant_cnt[w]++;
      end
      if (bus.core_start) begin
        check("start_after_grant", 64'(cyc - grant_cyc), 64'd1);
        start_cyc = cyc;
      end
      if (bus.rsp_valid && !prev_rv) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        else check("rsp_latency", 64'(cyc - start_cyc), 64'(rsp_q[0].rlat));
      end
      if (prev_rv && !prev_rr) begin
        check("hold_valid", 64'(bus.rsp_valid), 64'd1);
        check("hold_data",  bus.rsp_data,       prev_data);
        check("hold_id",    64'(bus.rsp_id),    64'(prev_id));
        check("hold_err",   64'(bus.rsp_err),   64'(prev_err));
      end
      if (bus.rsp_valid && bus.rsp_ready && rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        check("rsp_id",   64'(bus.rsp_id),  64'(r.id));
        check("rsp_data", bus.rsp_data,     r.data);
        check("rsp_err",  64'(bus.rsp_err), 64'(r.err));
        job_active = 1'b0;
      end
      prev_rv   = bus.rsp_valid;
      prev_rr   = bus.rsp_ready;
      prev_data = bus.rsp_data;
      prev_id   = bus.rsp_id;
      prev_err  = bus.rsp_err;
    end
  end

  // Core model: answers lat cycles after the start pulse (never when lat is 0).
  job_t cj;
  initial begin
    bus.core_out_valid = 1'b0;
    bus.core_desOut    = 64'd0;
    forever begin
      @(negedge clk);
      if (!reset && bus.core_start) begin
        if (core_q.size() == 0) begin
          check("core_start_unexpected", 64'(bus.core_start), 64'd0);
        end else begin
          cj = core_q.pop_front();
          check("core_desIn",   bus.core_desIn,        cj.data);
          check("core_decrypt", 64'(bus.core_decrypt), 64'(cj.dec));
          if (cj.lat != 0) begin
            repeat (cj.lat) @(posedge clk);
            #1;
            bus.core_out_valid = 1'b1;
            bus.core_desOut    = core_fn(bus.core_desIn, bus.core_decrypt);
            @(posedge clk);
            #1;
            bus.core_out_valid = 1'b0;
            bus.core_desOut    = {$urandom, $urandom};
          end
        end
      end
    end
  end

  int k;
  int base;
  initial begin
    bus.req_valid   = 2'b00;
    bus.req_data0   = 64'd0;
    bus.req_data1   = 64'd0;
    bus.req_decrypt = 2'b00;
    bus.key_ready   = 1'b0;
    bus.rsp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    tick();
    reset = 1'b0;

    // Key gating, then the reference single job once the key arrives.
    new_job(0, 64'h0123_4567_89AB_CDEF, 1'b0, 10);
    repeat (20) tick();
    bus.key_ready = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    check("key_rise_grant", 64'(bus.req_ready), 64'd1);
    wait_until_idle("single_job_done");

    // Both requesters held busy for three grants.
    base = grant_cnt[0] + grant_cnt[1];
    k = 0;
    while (grant_cnt[0] + grant_cnt[1] < base + 3 && k < 500) begin
      for (int i = 0; i < 2; i++)
        if (!bus.req_valid[i]) new_job(i, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                                       int'($urandom_range(1, T)));
      tick();
      k++;
    end
    check("contention_grants", 64'(grant_cnt[0] + grant_cnt[1] - base), 64'd3);
    wait_until_idle("contention_done");

    // Response backpressure with requester 1 waiting behind it.
    bus.rsp_ready = 1'b0;
    new_job(0, {$urandom, $urandom}, 1'b0, 3);
    k = 0;
    while (!bus.rsp_valid && k < 100) begin
      tick();
      k++;
    end
    check("bp_rsp_seen", 64'(bus.rsp_valid), 64'd1);
    new_job(1, {$urandom, $urandom}, 1'b1, 4);
    repeat (5) tick();
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_next_grant", 64'(bus.req_ready), 64'd2);
    wait_until_idle("bp_done");

    rand_mode = 1'b1;
    repeat (400) tick();
    rand_mode = 1'b0;
    bus.key_ready = 1'b1;
    bus.rsp_ready = 1'b1;
    wait_until_idle("random_drain");

    // Reset three cycles into a job; the late core strobe must go nowhere.
    new_job(0, 64'hFEDC_BA98_7654_3210, 1'b1, 10);
    k = 0;
    while (!bus.core_start && k < 20) begin
      tick();
      k++;
    end
    check("rb_start_seen", 64'(bus.core_start), 64'd1);
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    tick();
    tick();
    reset = 1'b0;
    repeat (15) tick();
    check("rb_idle_busy",  64'(bus.busy),      64'd0);
    check("rb_idle_rsp",   64'(bus.rsp_valid), 64'd0);
    new_job(0, {$urandom, $urandom}, 1'b0, 5);
    new_job(1, {$urandom, $urandom}, 1'b1, 5);
    #1;
    check("tie_after_reset", 64'(bus.req_ready), 64'd1);
    wait_until_idle("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
